// File: rtl/plru_pkg.sv
// ----------------------------------------------------------------------------
// plru_pkg
// Shared types and helpers for the tree pseudo-LRU replacement tracker.
//   state_t          : tracker state (INIT sweep / READY)
//   node_count()     : node bits per set for a given associativity
//   way_on_path()    : does a node lie on the root-to-leaf path of a way
//   way_in_left()    : does a way lie in a node's left subtree
//   onehot0_to_bin() : one-hot0 to binary way encoder
// Nodes are heap-indexed. Node k has children 2k+1 and 2k+2, and the leaves
// map to ways 0..NUM_WAYS-1 from left to right.
// ----------------------------------------------------------------------------
package plru_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int node_count(input int num_ways);
        return num_ways - 1;
    endfunction

    // Depth of a heap node: floor(log2(node+1)).
    function automatic int node_depth(input int node);
        int d;
        d = 0;
        for (int i = 1; i < 32; i++) begin
            if (((node + 1) >> i) != 0) d = i;
        end
        return d;
    endfunction

    // A node at depth d covers a contiguous span of NUM_WAYS>>d ways.
    function automatic logic way_on_path(input int node, input int way, input int num_ways);
        int d, off, span;
        d    = node_depth(node);
        off  = node + 1 - (1 << d);
        span = num_ways >> d;
        return (way >= off * span) && (way < off * span + span);
    endfunction

    function automatic logic way_in_left(input int node, input int way, input int num_ways);
        int d, off, span;
        d    = node_depth(node);
        off  = node + 1 - (1 << d);
        span = num_ways >> d;
        return (way >= off * span) && (way < off * span + span / 2);
    endfunction

    // OR-based encoder: exact for one-hot0 input, all-zero maps to 0.
    function automatic int onehot0_to_bin(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_tree_walk.sv
// ----------------------------------------------------------------------------
// plru_tree_walk
// Combinational PLRU victim walk: starts at the root and follows the node
// bits (0 = go left, 1 = go right) down to a leaf.
//   i_nodes  [NUM_WAYS-2:0] : heap-indexed node bits of one set
//   o_victim [NUM_WAYS-1:0] : one-hot victim way
// ----------------------------------------------------------------------------
module plru_tree_walk
    import plru_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0] i_nodes,
    output logic [NUM_WAYS-1:0] o_victim
);

    localparam int LEVELS = $clog2(NUM_WAYS);

    int   w_idx;
    logic w_bit;

    always_comb begin
        w_idx    = 0;
        w_bit    = 1'b0;
        o_victim = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            w_bit = 1'b0;
            for (int k = 0; k < NUM_WAYS - 1; k++) begin
                if (k == w_idx) w_bit = i_nodes[k];
            end
            w_idx = w_bit ? (2 * w_idx + 2) : (2 * w_idx + 1);
        end
        // Leaves follow the NUM_WAYS-1 internal nodes in heap order.
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_idx - (NUM_WAYS - 1) == w) o_victim[w] = 1'b1;
        end
    end

endmodule

// File: rtl/plru_victim_select.sv
// ----------------------------------------------------------------------------
// plru_victim_select
// Per-set tree pseudo-LRU tracker. Touches mark a way MRU by pointing every
// node on its path away from it; victim lookups return a registered one-hot
// way one cycle after the request. After reset, an INIT sweep clears one set
// per cycle so the node array needs no reset of its own.
//   clk, rst_n                   : clock, synchronous active-low reset
//   ready                        : high once the init sweep is complete
//   touch_valid/set/way          : access update (one-hot0 way, zero = none)
//   victim_req/set               : victim lookup strobe and set
//   victim_valid/way             : registered lookup result
// Optional feature (macro PLRU_FILL_TOUCH_EN): an accepted victim lookup also
// marks the chosen victim MRU, unless an explicit touch hits the same set.
// ----------------------------------------------------------------------------
module plru_victim_select
    import plru_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 64,
    parameter int SET_WIDTH = $clog2(NUM_SETS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 touch_valid,
    input  logic [SET_WIDTH-1:0] touch_set,
    input  logic [NUM_WAYS-1:0]  touch_way,
    input  logic                 victim_req,
    input  logic [SET_WIDTH-1:0] victim_set,
    output logic                 victim_valid,
    output logic [NUM_WAYS-1:0]  victim_way
);

    localparam int NODES = node_count(NUM_WAYS);

    state_t               r_state, w_state_nxt;
    logic [SET_WIDTH-1:0] r_cnt;
    logic [NODES-1:0]     r_nodes [NUM_SETS];
    logic                 r_victim_valid;
    logic [NUM_WAYS-1:0]  r_victim_way;

    logic                 w_ready;
    logic                 w_touch_en;
    logic                 w_victim_accept;
    logic                 w_fill_en;
    logic [NUM_WAYS-1:0]  w_victim_oh;
    logic [NODES-1:0]     w_touch_nodes;
    logic [NODES-1:0]     w_fill_nodes;

    // Point every node on the way's path away from it; leave the rest alone.
    function automatic logic [NODES-1:0] apply_touch(input logic [NODES-1:0] nodes, input int way);
        logic [NODES-1:0] res;
        res = nodes;
        for (int k = 0; k < NODES; k++) begin
            if (way_on_path(k, way, NUM_WAYS)) res[k] = way_in_left(k, way, NUM_WAYS);
        end
        return res;
    endfunction

    // ---- FSM: state register ----
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---- FSM: next-state logic ----
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == INIT && r_cnt == SET_WIDTH'(NUM_SETS - 1)) w_state_nxt = READY;
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_ready = (r_state == READY);
    end

    assign ready = w_ready;

    // ---- victim walk on pre-update state of the requested set ----
    plru_tree_walk #(.NUM_WAYS(NUM_WAYS)) u_walk (
        .i_nodes  (r_nodes[victim_set]),
        .o_victim (w_victim_oh)
    );

    assign w_victim_accept = w_ready && victim_req;
    assign w_touch_en      = w_ready && touch_valid && (|touch_way);
    assign w_touch_nodes   = apply_touch(r_nodes[touch_set], onehot0_to_bin(32'(touch_way)));
    assign w_fill_nodes    = apply_touch(r_nodes[victim_set], onehot0_to_bin(32'(w_victim_oh)));

`ifdef PLRU_FILL_TOUCH_EN
    // Explicit touch to the same set wins; the fill-touch is dropped.
    assign w_fill_en = w_victim_accept && !(w_touch_en && (touch_set == victim_set));
`else
    assign w_fill_en = 1'b0;
`endif

    // ---- node array ----
    // NOTE: the array is deliberately not reset; the INIT sweep clears it one
    // set per cycle so it can map onto a single-port-per-write SRAM later.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == INIT) begin
                r_nodes[r_cnt] <= '0;
            end else begin
                if (w_touch_en) r_nodes[touch_set]  <= w_touch_nodes;
                if (w_fill_en)  r_nodes[victim_set] <= w_fill_nodes;
            end
        end
    end

    // ---- registered victim result, held until the next accepted request ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_victim_valid <= 1'b0;
            r_victim_way   <= '0;
        end else begin
            r_victim_valid <= w_victim_accept;
            if (w_victim_accept) r_victim_way <= w_victim_oh;
        end
    end

    assign victim_valid = r_victim_valid;
    assign victim_way   = r_victim_way;

    a_touch_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        touch_valid |-> $onehot0(touch_way));

endmodule

// File: tb/tb_plru_victim_select.sv
// ----------------------------------------------------------------------------
// tb_plru_victim_select
// Directed bench for plru_victim_select (4 ways, 64 sets). Inputs change one
// time unit after the rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_plru_victim_select;

    localparam int NUM_WAYS  = 4;
    localparam int NUM_SETS  = 64;
    localparam int SET_WIDTH = 6;

    logic                 clk;
    logic                 rst_n;
    logic                 ready;
    logic                 touch_valid;
    logic [SET_WIDTH-1:0] touch_set;
    logic [NUM_WAYS-1:0]  touch_way;
    logic                 victim_req;
    logic [SET_WIDTH-1:0] victim_set;
    logic                 victim_valid;
    logic [NUM_WAYS-1:0]  victim_way;

    int n_checks = 0;
    int n_errors = 0;

    plru_victim_select #(
        .NUM_WAYS  (NUM_WAYS),
        .NUM_SETS  (NUM_SETS),
        .SET_WIDTH (SET_WIDTH)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready        (ready),
        .touch_valid  (touch_valid),
        .touch_set    (touch_set),
        .touch_way    (touch_way),
        .victim_req   (victim_req),
        .victim_set   (victim_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges after reset release; ready must stay low for exactly 64.
    task automatic release_and_sweep(input string tag);
        rst_n = 1'b1;
        for (int i = 1; i <= NUM_SETS; i++) begin
            step();
            if (i == NUM_SETS - 1) check({tag, "_ready_low_last"}, 32'(ready), 32'd0);
            if (i == NUM_SETS)     check({tag, "_ready_high"}, 32'(ready), 32'd1);
        end
    endtask

    task automatic touch(input int set, input logic [NUM_WAYS-1:0] way);
        touch_valid = 1'b1;
        touch_set   = SET_WIDTH'(set);
        touch_way   = way;
        step();
        touch_valid = 1'b0;
        touch_way   = '0;
    endtask

    // One-cycle victim request, result checked in the following cycle.
    task automatic lookup(input string tag, input int set, input logic [NUM_WAYS-1:0] exp);
        victim_req = 1'b1;
        victim_set = SET_WIDTH'(set);
        step();
        victim_req = 1'b0;
        check({tag, "_valid"}, 32'(victim_valid), 32'd1);
        check({tag, "_way"}, 32'(victim_way), 32'(exp));
    endtask

    logic [NUM_WAYS-1:0] exp_b2b [3];

    initial begin
        rst_n       = 1'b0;
        touch_valid = 1'b0;
        touch_set   = '0;
        touch_way   = '0;
        victim_req  = 1'b0;
        victim_set  = '0;
        repeat (3) step();

        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(victim_valid), 32'd0);
        check("rst_way", 32'(victim_way), 32'd0);

        // Requests during the sweep are ignored.
        victim_req = 1'b1;
        release_and_sweep("sweep1");
        victim_req = 1'b0;
        step();
        check("init_req_ignored_valid", 32'(victim_valid), 32'd0);
        check("init_req_ignored_way", 32'(victim_way), 32'd0);

        // Fresh state: every walk goes left to way 0.
        lookup("fresh_s0", 0, 4'b0001);
        step();
        check("valid_drop", 32'(victim_valid), 32'd0);
        check("way_hold", 32'(victim_way), 32'(4'b0001));
        lookup("fresh_s63", 63, 4'b0001);

        // Set 5: touch way 0 -> {root=1,n1=1,n2=0} -> way 2.
        touch(5, 4'b0001);
        lookup("s5_after_t0", 5, 4'b0100);
        touch(5, 4'b0100);
        lookup("s5_after_t2", 5, 4'b0010);

        // Zero touch vector is not an update.
        touch(5, 4'b0000);
        lookup("s5_zero_touch", 5, 4'b0010);

        // Same-cycle touch and lookup on set 3: walk sees pre-touch state.
        touch_valid = 1'b1;
        touch_set   = 6'd3;
        touch_way   = 4'b0001;
        victim_req  = 1'b1;
        victim_set  = 6'd3;
        step();
        touch_valid = 1'b0;
        touch_way   = '0;
        victim_req  = 1'b0;
        check("s3_same_cycle_way", 32'(victim_way), 32'(4'b0001));
        lookup("s3_next", 3, 4'b0100);

        // Back-to-back lookups on untouched set 9.
`ifdef PLRU_FILL_TOUCH_EN
        exp_b2b[0] = 4'b0001;
        exp_b2b[1] = 4'b0100;
        exp_b2b[2] = 4'b0010;
`else
        exp_b2b[0] = 4'b0001;
        exp_b2b[1] = 4'b0001;
        exp_b2b[2] = 4'b0001;
`endif
        victim_req = 1'b1;
        victim_set = 6'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("b2b%0d_valid", i), 32'(victim_valid), 32'd1);
            check($sformatf("b2b%0d_way", i), 32'(victim_way), 32'(exp_b2b[i]));
        end
        victim_req = 1'b0;
        step();
        check("b2b_valid_drop", 32'(victim_valid), 32'd0);

        // Touch sets 0..7 with various ways, then reset while READY.
        for (int s = 0; s < 8; s++) touch(s, 4'b0001 << (s % 4));
        lookup("s1_touched", 1, 4'b0100);
        rst_n = 1'b0;
        step();
        step();
        check("rst2_ready", 32'(ready), 32'd0);
        check("rst2_valid", 32'(victim_valid), 32'd0);
        check("rst2_way", 32'(victim_way), 32'd0);
        release_and_sweep("sweep2");
        for (int s = 0; s < 8; s++) lookup($sformatf("post_rst_s%0d", s), s, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/plru_victim_select.md
# plru_victim_select

Per-set tree pseudo-LRU replacement tracker for the set-associative cache. It takes one-hot hit/fill way vectors from tag compare and updates per-set PLRU state. On request, it returns a registered one-hot victim way for the fill path, which feeds the one-hot-to-binary encoder for way-index muxing. After reset it runs a clearing sweep so that the state array can later map onto SRAM.

## Interface
- NUM_WAYS, 4, associativity; power of two, ≥ 2
- NUM_SETS, 64, number of sets; power of two, ≥ 2
- SET_WIDTH, $clog2(NUM_SETS), set index width
- clk  input  1  sole clock, all logic rising-edge
- rst_n  input  1  synchronous, active-low reset
- ready  output  1  high once the init sweep is complete
- touch_valid  input  1  access-update strobe
- touch_set  input  SET_WIDTH  set being updated
- touch_way  input  NUM_WAYS  one-hot0 way accessed; all-zero means no update
- victim_req  input  1  victim lookup strobe
- victim_set  input  SET_WIDTH  set to look up
- victim_valid  output  1  registered; high exactly one cycle after an accepted victim_req
- victim_way  output  NUM_WAYS  registered one-hot victim; held until the next accepted request

## Operation
- Each set holds NUM_WAYS-1 heap-indexed node bits. Node k has children 2k+1 and 2k+2, and the leaves map to ways 0..NUM_WAYS-1 from left to right.
- Node bit meaning: 0 means the victim lies in the left subtree; 1 means it lies in the right subtree.
- Touch of way w: every node on the root-to-w path is set to point away from w. The node becomes 1 if w is in its left subtree and 0 if w is in its right subtree. Off-path nodes are unchanged.
- Victim walk: start at the root and follow the node bits to a leaf. victim_way is the one-hot of that leaf.
- States:
  - INIT: a set counter runs 0..NUM_SETS-1 and writes all-zero node bits for one set per cycle. ready=0. touch and victim_req are ignored.
  - READY: reached after counter = NUM_SETS-1. ready=1. Requests are accepted every cycle.
- touch_way is encoded to binary internally. If more than one bit is set, behaviour is undefined and an assertion fires in simulation.
- Simultaneous touch and victim_req, including to the same set: the victim walk uses the node state from before this cycle's touch. The touch commits at the same edge.
- Back-to-back victim_req is allowed. Each request gets its own victim_valid pulse one cycle later.

## Timing
- Reset (rst_n=0 at an edge): state→INIT, counter→0, ready=0, victim_valid=0, victim_way=0.
- Reset asserted mid-sweep or in READY restarts the sweep from set 0. The node array is fully rewritten.
- ready rises NUM_SETS cycles after the first edge with rst_n=1.
- Victim latency is 1 cycle: victim_req sampled at edge N produces victim_valid=1 and victim_way after edge N, visible during cycle N+1.
- A touch at edge N is visible to a victim walk sampled at edge N+1.
- victim_valid drops the cycle after the last request. victim_way holds its value.

## Configuration
- PLRU_FILL_TOUCH_EN defined:
  - An accepted victim_req also touches the chosen victim way in victim_set at the same edge, marking it MRU.
  - If touch_valid with a nonzero touch_way targets the same set in the same cycle, the explicit touch wins and the fill-touch is dropped.
  - Different sets: both updates commit.
- PLRU_FILL_TOUCH_EN undefined: victim_req never modifies the node array.

## Structure
- Package plru_pkg holds:
  - the state enum {INIT, READY}
  - a node-count constant function (NUM_WAYS-1)
  - a path helper function returning, for a node index and a way index, whether the way lies in the left subtree
- Sub-module plru_tree_walk: a combinational node-bits→one-hot victim walk, reusable by the fill path.
- The touch vector encoding reuses the existing one-hot0-to-binary encoder.

## Test plan
- Reset sweep, NUM_SETS=64: release rst_n → ready=0 for 64 cycles, then ready=1. A victim_req on any set → victim_way=4'b0001.
- 4-way, set 5: touch way 0 (4'b0001), then victim_req set 5 → node bits {root=1, n1=1, n2=0} and victim_way=4'b0100. Then touch way 2 → victim_way=4'b0010.
- Same-cycle touch way 0 and victim_req on set 3 from the reset state → victim_way=4'b0001 (pre-touch state). The next request → 4'b0100.
- touch_way=4'b0000 with touch_valid=1 → node bits unchanged, and the following victim matches the prior victim.
- Reset asserted in READY after touches to sets 0..7 → ready=0 for 64 cycles, and all sets then return victim_way=4'b0001.
- With PLRU_FILL_TOUCH_EN: three back-to-back victim_req on set 9 from reset → 4'b0001, 4'b0100, 4'b0010. Without the macro → 4'b0001 three times.
